// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM controller: debounced-free switch edges pick a channel's target
// duty and start/stop it; applied duty slews toward its goal at the ramp rate.

module pwm_lane #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_hit,
    input  logic             dec_hit,
    input  logic             tgl,
    input  logic             tick,
    input  logic [WIDTH-1:0] pwm_cnt,
    output logic             pwm_out,
    output logic             running,
    output logic             ramping,
    output logic [WIDTH-1:0] target
);
    typedef enum logic [1:0] {STOPPED, ACTIVE, STOPPING} state_t;

    localparam logic [WIDTH-1:0] MAX_W  = '1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t           state, state_nx;
    logic [WIDTH-1:0] applied, compare, goal;
    logic [WIDTH:0]   inc_sum;

    assign inc_sum = {1'b0, target} + {1'b0, STEP_W};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= '0;
        end else if (inc_hit) begin
            target <= (inc_sum > {1'b0, MAX_W}) ? MAX_W : inc_sum[WIDTH-1:0];
        end else if (dec_hit) begin
            target <= (target < STEP_W) ? '0 : target - STEP_W;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= STOPPED;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        goal     = '0;
        running  = 1'b0;
        case (state)
            STOPPED: begin
                if (tgl) state_nx = ACTIVE;
            end
            ACTIVE: begin
                goal    = target;
                running = 1'b1;
                if (tgl) state_nx = STOPPING;
            end
            STOPPING: begin
                running = 1'b1;
                if (tgl)                 state_nx = ACTIVE;
                else if (applied == '0)  state_nx = STOPPED;
            end
            default: state_nx = STOPPED;
        endcase
    end

    assign ramping = (applied != goal);

    // compare only reloads at period start so a period is never cut short or stretched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            applied <= '0;
            compare <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (tick) begin
                if (applied < goal)      applied <= applied + 1'b1;
                else if (applied > goal) applied <= applied - 1'b1;
            end
            if (pwm_cnt == '0) compare <= applied;
            pwm_out <= running && (pwm_cnt < compare);
        end
    end
endmodule

module pwm_multi_ctrl #(
    parameter int  CHANNELS = 4,
    parameter int  WIDTH    = 8,
    parameter int  STEP     = 1,
    parameter int  RAMP_DIV = 1024,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    sel,
    input  logic                inc,
    input  logic                dec,
    input  logic                start_stop,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] running,
    output logic [WIDTH-1:0]    duty_sel,
    output logic [CHANNELS-1:0] ramping
);
    localparam int             PW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(RAMP_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((2 ** WIDTH) - 2);

    // bit 0 inc, bit 1 dec, bit 2 start_stop
    logic [2:0] sync_s1, sync_s2, sync_d, edge_raw;
    logic [1:0] guard;
    logic       en, sel_ok, inc_e, dec_e, tgl_e, tick;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] pwm_cnt;
    logic [CHANNELS-1:0][WIDTH-1:0] targets;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            sync_d  <= '0;
            guard   <= '0;
        end else begin
            sync_s1 <= {start_stop, dec, inc};
            sync_s2 <= sync_s1;
            sync_d  <= sync_s2;
            if (guard != 2'd3) guard <= guard + 2'd1;
        end
    end

    // guard holds off the first three edges so a switch held through reset is not seen as a press
    assign en       = (guard == 2'd3);
    assign edge_raw = sync_s2 & ~sync_d;
    assign sel_ok   = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));
    assign inc_e    = en && sel_ok && edge_raw[0] && !edge_raw[1];
    assign dec_e    = en && sel_ok && edge_raw[1] && !edge_raw[0];
    assign tgl_e    = en && sel_ok && edge_raw[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc   <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
            pwm_cnt <= (pwm_cnt >= CNT_LAST) ? '0 : pwm_cnt + 1'b1;
        end
    end

    assign tick = (presc == PRE_LAST);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic hit;
        assign hit = (sel == SEL_W'(i));
        pwm_lane #(.WIDTH(WIDTH), .STEP(STEP)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .inc_hit (inc_e && hit),
            .dec_hit (dec_e && hit),
            .tgl     (tgl_e && hit),
            .tick    (tick),
            .pwm_cnt (pwm_cnt),
            .pwm_out (pwm_out[i]),
            .running (running[i]),
            .ramping (ramping[i]),
            .target  (targets[i])
        );
    end

    assign duty_sel = sel_ok ? targets[sel] : '0;
endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl with 2 channels, 4-bit duty, ramp every 2 cycles.

module tb_pwm_multi_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:0] sel = 1'b0;
    logic       inc = 1'b0, dec = 1'b0, start_stop = 1'b0;
    logic [1:0] pwm_out, running, ramping;
    logic [3:0] duty_sel;

    int total = 0;
    int bad   = 0;

    pwm_multi_ctrl #(.CHANNELS(2), .WIDTH(4), .STEP(1), .RAMP_DIV(2)) dut (
        .clk(clk), .rst(rst), .sel(sel), .inc(inc), .dec(dec),
        .start_stop(start_stop), .pwm_out(pwm_out), .running(running),
        .duty_sel(duty_sel), .ramping(ramping)
    );

    always #5 clk = ~clk;

    task set_sw(input int which, input logic v);
        case (which)
            0: inc = v;
            1: dec = v;
            default: start_stop = v;
        endcase
    endtask

    task pulse(input int which);
        @(negedge clk);
        set_sw(which, 1'b1);
        repeat (4) @(negedge clk);
        set_sw(which, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    // raise start_stop and return at the first sample after the action edge
    task raise_start();
        @(negedge clk);
        start_stop = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task count_ramp(input int ch, output int n);
        n = 0;
        while (ramping[ch] && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task test_reset();
        repeat (2) @(negedge clk);
        total++; if (pwm_out !== 2'b00) begin bad++; $display("FAIL reset_pwm got=%b want=00", pwm_out); end
        total++; if (running !== 2'b00) begin bad++; $display("FAIL reset_running got=%b want=00", running); end
        total++; if (ramping !== 2'b00) begin bad++; $display("FAIL reset_ramping got=%b want=00", ramping); end
        total++; if (duty_sel !== 4'd0) begin bad++; $display("FAIL reset_duty got=%0d want=0", duty_sel); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task test_inc_dec();
        sel = 1'b0;
        repeat (5) pulse(0);
        total++; if (duty_sel !== 4'd5) begin bad++; $display("FAIL inc5_duty got=%0d want=5", duty_sel); end
        total++; if (running !== 2'b00) begin bad++; $display("FAIL inc5_running got=%b want=00", running); end
        total++; if (pwm_out !== 2'b00) begin bad++; $display("FAIL inc5_pwm got=%b want=00", pwm_out); end
        repeat (20) pulse(0);
        total++; if (duty_sel !== 4'd15) begin bad++; $display("FAIL inc_sat got=%0d want=15", duty_sel); end
        repeat (20) pulse(1);
        total++; if (duty_sel !== 4'd0) begin bad++; $display("FAIL dec_sat got=%0d want=0", duty_sel); end
    endtask

    task test_same_edge();
        repeat (3) pulse(0);
        @(negedge clk);
        inc = 1'b1; dec = 1'b1;
        repeat (4) @(negedge clk);
        inc = 1'b0; dec = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (duty_sel !== 4'd3) begin bad++; $display("FAIL same_edge got=%0d want=3", duty_sel); end
        inc = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (duty_sel !== 4'd0) begin bad++; $display("FAIL held_thru_reset got=%0d want=0", duty_sel); end
        inc = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task test_ramp_up();
        int n, h0, h1;
        repeat (10) pulse(0);
        total++; if (duty_sel !== 4'd10) begin bad++; $display("FAIL tgt10 got=%0d want=10", duty_sel); end
        raise_start();
        total++; if (running !== 2'b01) begin bad++; $display("FAIL start_running got=%b want=01", running); end
        total++; if (ramping !== 2'b01) begin bad++; $display("FAIL start_ramping got=%b want=01", ramping); end
        start_stop = 1'b0;
        count_ramp(0, n);
        total++; if (n < 19 || n > 20) begin bad++; $display("FAIL ramp_up_len got=%0d want=19..20", n); end
        total++; if (running !== 2'b01) begin bad++; $display("FAIL ramp_done_running got=%b want=01", running); end
        repeat (20) @(negedge clk);
        h0 = 0; h1 = 0;
        for (int k = 0; k < 30; k++) begin
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            @(negedge clk);
        end
        total++; if (h0 != 20) begin bad++; $display("FAIL duty10_highs got=%0d want=20/30", h0); end
        total++; if (h1 != 0) begin bad++; $display("FAIL ch1_idle got=%0d want=0", h1); end
    endtask

    task test_stop_restart();
        int n, h;
        raise_start();
        total++; if (running[0] !== 1'b1 || ramping[0] !== 1'b1) begin
            bad++; $display("FAIL stopping_flags run=%b ramp=%b want=1,1", running[0], ramping[0]);
        end
        start_stop = 1'b0;
        count_ramp(0, n);
        total++; if (n < 19 || n > 20) begin bad++; $display("FAIL ramp_down_len got=%0d want=19..20", n); end
        total++; if (running[0] !== 1'b1) begin bad++; $display("FAIL still_stopping got=%b want=1", running[0]); end
        @(negedge clk);
        total++; if (running[0] !== 1'b0) begin bad++; $display("FAIL stopped got=%b want=0", running[0]); end
        @(negedge clk);
        h = 0;
        for (int k = 0; k < 20; k++) begin
            h += int'(pwm_out[0]);
            @(negedge clk);
        end
        total++; if (h != 0) begin bad++; $display("FAIL stopped_pwm got=%0d want=0", h); end
        raise_start();
        start_stop = 1'b0;
        count_ramp(0, n);
        total++; if (n < 19 || n > 20) begin bad++; $display("FAIL reramp_len got=%0d want=19..20", n); end
        total++; if (running[0] !== 1'b1) begin bad++; $display("FAIL restart_running got=%b want=1", running[0]); end
        total++; if (duty_sel !== 4'd10) begin bad++; $display("FAIL retained got=%0d want=10", duty_sel); end
    endtask

    task test_full_slew();
        int h, prev_rise, prev_len, last_len, rises, len, j;
        logic hist [0:169];
        repeat (5) pulse(0);
        repeat (40) @(negedge clk);
        h = 0;
        for (int k = 0; k < 30; k++) begin
            h += int'(pwm_out[0]);
            @(negedge clk);
        end
        total++; if (h != 30) begin bad++; $display("FAIL full_high got=%0d want=30", h); end
        fork
            repeat (12) pulse(1);
            for (int k = 0; k < 170; k++) begin
                @(negedge clk);
                hist[k] = pwm_out[0];
            end
        join
        total++; if (duty_sel !== 4'd3) begin bad++; $display("FAIL slew_tgt got=%0d want=3", duty_sel); end
        total++; if (ramping[0] !== 1'b0) begin bad++; $display("FAIL slew_settled got=%b want=0", ramping[0]); end
        prev_rise = -1; prev_len = 16; last_len = -1; rises = 0;
        for (int k = 1; k < 170; k++) begin
            if (hist[k] && !hist[k-1]) begin
                rises++;
                if (prev_rise >= 0) begin
                    total++; if (k - prev_rise != 15) begin
                        bad++; $display("FAIL period_boundary got=%0d want=15", k - prev_rise);
                    end
                end
                prev_rise = k;
                len = 0; j = k;
                while (j < 170 && hist[j]) begin len++; j++; end
                if (j < 170) begin
                    total++; if (len > prev_len) begin
                        bad++; $display("FAIL duty_monotonic got=%0d want<=%0d", len, prev_len);
                    end
                    prev_len = len;
                    last_len = len;
                end
            end
        end
        total++; if (rises < 3) begin bad++; $display("FAIL slew_periods got=%0d want>=3", rises); end
        total++; if (last_len != 3) begin bad++; $display("FAIL final_duty got=%0d want=3", last_len); end
    endtask

    task test_async_reset();
        sel = 1'b1;
        repeat (8) pulse(0);
        total++; if (duty_sel !== 4'd8) begin bad++; $display("FAIL ch1_tgt got=%0d want=8", duty_sel); end
        raise_start();
        start_stop = 1'b0;
        total++; if (running !== 2'b11) begin bad++; $display("FAIL both_running got=%b want=11", running); end
        repeat (4) @(negedge clk);
        total++; if (ramping[1] !== 1'b1) begin bad++; $display("FAIL mid_ramp got=%b want=1", ramping[1]); end
        #2 rst = 1'b1;
        #1;
        total++; if (pwm_out !== 2'b00) begin bad++; $display("FAIL async_pwm got=%b want=00", pwm_out); end
        total++; if (running !== 2'b00) begin bad++; $display("FAIL async_running got=%b want=00", running); end
        total++; if (ramping !== 2'b00) begin bad++; $display("FAIL async_ramping got=%b want=00", ramping); end
        total++; if (duty_sel !== 4'd0) begin bad++; $display("FAIL async_duty got=%0d want=0", duty_sel); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (running !== 2'b00 || pwm_out !== 2'b00) begin
            bad++; $display("FAIL post_reset run=%b pwm=%b want=00,00", running, pwm_out);
        end
        sel = 1'b0;
        total++; if (duty_sel !== 4'd0) begin bad++; $display("FAIL post_reset_tgt0 got=%0d want=0", duty_sel); end
    endtask

    initial begin
        test_reset();
        test_inc_dec();
        test_same_edge();
        test_ramp_up();
        test_stop_restart();
        test_full_slew();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
